// File: rtl/uart_arb_pkg.sv
// Purpose: shared types and constants for the two-master UART bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT0 = 3'd1,
        GRANT1 = 3'd2,
        ERR0   = 3'd3,
        ERR1   = 3'd4
    } arb_state_t;

    // Identifies one of the two masters (0 or 1).
    typedef logic master_id_t;

    // Default number of consecutive stalled cycles tolerated before abort.
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/uart_arb_timeout.sv
// Purpose: counts consecutive stalled cycles of the granted transfer.
// Latency: expired rises the cycle after the TIMEOUT-th stalled cycle.
// Backpressure: none; count_en low clears the count.
//
// Ports: clk, reset (sync, active-high), count_en (granted and slave stalling),
//        expired (count has reached TIMEOUT).
module uart_arb_timeout
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Saturates at TIMEOUT; the arbiter leaves GRANT the cycle it sees
    // expired, so the count is cleared right after.
    always_ff @(posedge clk) begin
        if (reset || !count_en) begin
            count <= '0;
        end else if (count != CW'(TIMEOUT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/uart_bus_arbiter.sv
// Purpose: round-robin arbiter sharing one UART peripheral port between two masters.
// Latency: 1 arbitration cycle + 1 transfer cycle minimum; slave stall extends the transfer.
// Backpressure: non-granted requesting master sees stall=1; granted master sees s_request_stall.
//
// Ports: clk, reset (sync, active-high);
//        mN_wen/mN_ren/mN_addr/mN_wdata/mN_strobe in, mN_rdata/mN_error/mN_stall out (N=0,1);
//        s_wen/s_ren/s_addr/s_wdata/s_strobe out, s_rdata/s_error/s_request_stall in.
// Optional: define UART_ARB_TIMEOUT_EN to abort transfers stalled for TIMEOUT cycles.
module uart_bus_arbiter
    import uart_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m0_wen,
    input  logic                    m0_ren,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_strobe,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_error,
    output logic                    m0_stall,
    input  logic                    m1_wen,
    input  logic                    m1_ren,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_strobe,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_error,
    output logic                    m1_stall,
    output logic                    s_wen,
    output logic                    s_ren,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_strobe,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic                    s_error,
    input  logic                    s_request_stall
);

    arb_state_t state, next_state, cur_state;
    master_id_t last_grant, next_last_grant;
    logic       m0_req, m1_req, m0_bad, m1_bad;
    logic       sel1, sel_req, sel_bad;
    logic       timeout_expired;

    assign m0_req = m0_wen | m0_ren;
    assign m1_req = m1_wen | m1_ren;
    assign m0_bad = m0_wen & m0_ren;
    assign m1_bad = m1_wen & m1_ren;

    // Outputs decode from IDLE while reset is held, so nothing is forwarded
    // even in the first reset cycle of an interrupted transfer.
    assign cur_state = reset ? IDLE : state;

    assign sel1    = (cur_state == GRANT1);
    assign sel_req = sel1 ? m1_req : m0_req;
    assign sel_bad = sel1 ? m1_bad : m0_bad;

`ifdef UART_ARB_TIMEOUT_EN
    uart_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .count_en (((state == GRANT0) || (state == GRANT1)) && s_request_stall),
        .expired  (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    always_comb begin
        next_state      = cur_state;
        next_last_grant = last_grant;
        s_wen           = 1'b0;
        s_ren           = 1'b0;
        s_addr          = '0;
        s_wdata         = '0;
        s_strobe        = '0;
        m0_rdata        = '0;
        m0_error        = 1'b0;
        m0_stall        = m0_req;
        m1_rdata        = '0;
        m1_error        = 1'b0;
        m1_stall        = m1_req;

        case (cur_state)
            IDLE: begin
                // Master 0 wins alone, or on a tie when master 1 went last.
                if (m0_req && (!m1_req || last_grant == 1'b1)) begin
                    next_state = m0_bad ? ERR0 : GRANT0;
                end else if (m1_req) begin
                    next_state = m1_bad ? ERR1 : GRANT1;
                end
            end

            GRANT0, GRANT1: begin
                if (!sel_req) begin
                    next_state = IDLE;
                end else if (sel_bad || timeout_expired) begin
                    // Never forward a malformed or timed-out request; the
                    // master stays stalled until the error pulse.
                    next_state = sel1 ? ERR1 : ERR0;
                end else begin
                    s_wen    = sel1 ? m1_wen    : m0_wen;
                    s_ren    = sel1 ? m1_ren    : m0_ren;
                    s_addr   = sel1 ? m1_addr   : m0_addr;
                    s_wdata  = sel1 ? m1_wdata  : m0_wdata;
                    s_strobe = sel1 ? m1_strobe : m0_strobe;
                    if (sel1) begin
                        m1_rdata = s_rdata;
                        m1_error = s_error;
                        m1_stall = s_request_stall;
                    end else begin
                        m0_rdata = s_rdata;
                        m0_error = s_error;
                        m0_stall = s_request_stall;
                    end
                    if (!s_request_stall) begin
                        next_state      = IDLE;
                        next_last_grant = sel1;
                    end
                end
            end

            // The erroring master counts as served for round-robin purposes.
            ERR0: begin
                m0_error        = 1'b1;
                m0_stall        = 1'b0;
                next_state      = IDLE;
                next_last_grant = 1'b0;
            end

            ERR1: begin
                m1_error        = 1'b1;
                m1_stall        = 1'b0;
                next_state      = IDLE;
                next_last_grant = 1'b1;
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
module tb_uart_bus_arbiter;
    import uart_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_wen, m0_ren, m1_wen, m1_ren;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_strobe, m1_strobe;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_error, m0_stall, m1_error, m1_stall;
    logic        s_wen, s_ren;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_strobe;
    logic        s_error, s_request_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_bus_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m0_wen          (m0_wen),
        .m0_ren          (m0_ren),
        .m0_addr         (m0_addr),
        .m0_wdata        (m0_wdata),
        .m0_strobe       (m0_strobe),
        .m0_rdata        (m0_rdata),
        .m0_error        (m0_error),
        .m0_stall        (m0_stall),
        .m1_wen          (m1_wen),
        .m1_ren          (m1_ren),
        .m1_addr         (m1_addr),
        .m1_wdata        (m1_wdata),
        .m1_strobe       (m1_strobe),
        .m1_rdata        (m1_rdata),
        .m1_error        (m1_error),
        .m1_stall        (m1_stall),
        .s_wen           (s_wen),
        .s_ren           (s_ren),
        .s_addr          (s_addr),
        .s_wdata         (s_wdata),
        .s_strobe        (s_strobe),
        .s_rdata         (s_rdata),
        .s_error         (s_error),
        .s_request_stall (s_request_stall)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_wen = 0; m0_ren = 0; m0_addr = 0; m0_wdata = 0; m0_strobe = 0;
        m1_wen = 0; m1_ren = 0; m1_addr = 0; m1_wdata = 0; m1_strobe = 0;
        s_rdata = 0; s_error = 0; s_request_stall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset  = 1;
        m0_ren = 1;
        tick();
        tick();
        n_checks++;
        if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        n_checks++;
        if ({s_wen, s_ren, s_addr, s_wdata, s_strobe} !== '0) begin n_fail++; $display("FAIL reset_s_out: got wen=%b ren=%b addr=%h want all 0", s_wen, s_ren, s_addr); end
        n_checks++;
        if ({m0_stall, m1_stall, m0_error, m1_error, m0_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL reset_m_out: got m0_stall=%b m1_stall=%b m0_err=%b want 1 0 0", m0_stall, m1_stall, m0_error);
        end
        m0_ren = 0;
        reset  = 0;
        tick();
    endtask

    task automatic test_single_write();
        m0_wen = 1; m0_addr = 24; m0_wdata = 32'h0F; m0_strobe = 4'hF;
        #1;
        n_checks++;
        if (s_wen !== 1'b0 || m0_stall !== 1'b1) begin n_fail++; $display("FAIL wr_arb_cycle: got s_wen=%b m0_stall=%b want 0 1", s_wen, m0_stall); end
        tick();
        n_checks++;
        if (s_wen !== 1'b1 || s_ren !== 1'b0 || s_addr !== 32'd24 || s_wdata !== 32'h0F || s_strobe !== 4'hF) begin
            n_fail++; $display("FAIL wr_xfer: got wen=%b ren=%b addr=%0d wdata=%h strb=%h want 1 0 24 0f f", s_wen, s_ren, s_addr, s_wdata, s_strobe);
        end
        n_checks++;
        if (m0_stall !== 1'b0) begin n_fail++; $display("FAIL wr_stall: got %b want 0", m0_stall); end
        tick();
        m0_wen = 0;
        #1;
        n_checks++;
        if (dut.state !== IDLE || s_wen !== 1'b0) begin n_fail++; $display("FAIL wr_done: got state=%0d s_wen=%b want %0d 0", dut.state, s_wen, IDLE); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m0_ren = 1; m0_addr = 32'h100;
        m1_ren = 1; m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (m0_stall !== 1'b1 || m1_stall !== 1'b1 || s_ren !== 1'b0) begin
                n_fail++; $display("FAIL rr_idle_%0d: got m0_stall=%b m1_stall=%b s_ren=%b want 1 1 0", i, m0_stall, m1_stall, s_ren);
            end
            tick();
            n_checks++;
            if (s_ren !== 1'b1 || s_addr !== ((i % 2 == 0) ? 32'h100 : 32'h200)) begin
                n_fail++; $display("FAIL rr_grant_%0d: got s_ren=%b s_addr=%h want 1 %h", i, s_ren, s_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            end
            n_checks++;
            if ({m0_stall, m1_stall} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL rr_loser_%0d: got m0_stall=%b m1_stall=%b", i, m0_stall, m1_stall);
            end
            tick();
        end
        m0_ren = 0; m1_ren = 0;
        tick();
    endtask

    task automatic test_stalled_read();
        m1_ren = 1; m1_addr = 32'h8; s_request_stall = 1; s_rdata = 32'h0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (m1_stall !== 1'b1 || s_ren !== 1'b1 || s_addr !== 32'h8) begin
                n_fail++; $display("FAIL stall_cycle_%0d: got m1_stall=%b s_ren=%b s_addr=%h want 1 1 8", i, m1_stall, s_ren, s_addr);
            end
            tick();
        end
        s_request_stall = 0; s_rdata = 32'hA5;
        #1;
        n_checks++;
        if (m1_rdata !== 32'hA5 || m1_stall !== 1'b0) begin n_fail++; $display("FAIL stall_data: got rdata=%h stall=%b want a5 0", m1_rdata, m1_stall); end
        tick();
        m1_ren = 0;
        #1;
        n_checks++;
        if (m1_rdata !== 32'h0 || m1_stall !== 1'b0 || m0_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata: got m1=%h m0=%h stall=%b want 0", m1_rdata, m0_rdata, m1_stall); end
        s_rdata = 0;
        tick();
    endtask

    task automatic test_malformed();
        m0_wen = 1; m0_ren = 1; m0_addr = 32'h44;
        #1;
        n_checks++;
        if (s_wen !== 1'b0 || s_ren !== 1'b0 || m0_error !== 1'b0) begin n_fail++; $display("FAIL bad_arb: got s_wen=%b s_ren=%b err=%b want 0 0 0", s_wen, s_ren, m0_error); end
        tick();
        n_checks++;
        if (s_wen !== 1'b0 || s_ren !== 1'b0 || m0_error !== 1'b1 || m0_stall !== 1'b0) begin
            n_fail++; $display("FAIL bad_err: got s_wen=%b s_ren=%b err=%b stall=%b want 0 0 1 0", s_wen, s_ren, m0_error, m0_stall);
        end
        m0_ren = 0;
        tick();
        n_checks++;
        if (m0_error !== 1'b0 || m0_stall !== 1'b1 || s_wen !== 1'b0) begin n_fail++; $display("FAIL bad_once: got err=%b stall=%b s_wen=%b want 0 1 0", m0_error, m0_stall, s_wen); end
        tick();
        n_checks++;
        if (s_wen !== 1'b1 || s_addr !== 32'h44 || m0_error !== 1'b0) begin n_fail++; $display("FAIL bad_next: got s_wen=%b addr=%h err=%b want 1 44 0", s_wen, s_addr, m0_error); end
        tick();
        m0_wen = 0;
        tick();
    endtask

    // last_grant is 0 here; an aborted master-1 grant must not change it.
    task automatic test_abort();
        m1_ren = 1; m1_addr = 32'h300; s_request_stall = 1;
        tick();
        m1_ren = 0;
        #1;
        n_checks++;
        if (s_ren !== 1'b0 || m1_stall !== 1'b0) begin n_fail++; $display("FAIL abort_fwd: got s_ren=%b m1_stall=%b want 0 0", s_ren, m1_stall); end
        s_request_stall = 0;
        tick();
        m0_ren = 1; m0_addr = 32'h100; m1_ren = 1;
        tick();
        n_checks++;
        if (s_addr !== 32'h300 || m1_stall !== 1'b0 || m0_stall !== 1'b1) begin
            n_fail++; $display("FAIL abort_rr: got s_addr=%h m1_stall=%b m0_stall=%b want 300 0 1", s_addr, m1_stall, m0_stall);
        end
        tick();
        m0_ren = 0; m1_ren = 0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        m0_wen = 1; m0_addr = 32'h10; m1_ren = 1; m1_addr = 32'h20; s_request_stall = 1;
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (s_wen !== 1'b1 || m0_error !== 1'b0 || m0_stall !== 1'b1) begin
                n_fail++; $display("FAIL to_stalled_%0d: got s_wen=%b err=%b stall=%b want 1 0 1", i, s_wen, m0_error, m0_stall);
            end
            tick();
        end
        n_checks++;
        if (s_wen !== 1'b0 || s_ren !== 1'b0) begin n_fail++; $display("FAIL to_deassert: got s_wen=%b s_ren=%b want 0 0", s_wen, s_ren); end
        tick();
        n_checks++;
        if (m0_error !== 1'b1 || m0_stall !== 1'b0) begin n_fail++; $display("FAIL to_err: got err=%b stall=%b want 1 0", m0_error, m0_stall); end
        m0_wen = 0;
        tick();
        tick();
        n_checks++;
        if (s_ren !== 1'b1 || s_addr !== 32'h20) begin n_fail++; $display("FAIL to_next: got s_ren=%b s_addr=%h want 1 20", s_ren, s_addr); end
        s_request_stall = 0;
        tick();
`else
        for (int i = 0; i < 100; i++) tick();
        n_checks++;
        if (s_wen !== 1'b1 || m0_stall !== 1'b1 || m1_stall !== 1'b1 || m0_error !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout: got s_wen=%b m0_stall=%b m1_stall=%b err=%b want 1 1 1 0", s_wen, m0_stall, m1_stall, m0_error);
        end
        s_request_stall = 0;
        tick();
        m0_wen = 0;
        tick();
`endif
        m0_wen = 0; m1_ren = 0; s_request_stall = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        m1_ren = 1; m1_addr = 32'h20; s_request_stall = 1;
        tick();
        tick();
        n_checks++;
        if (s_ren !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got s_ren=%b want 1", s_ren); end
        reset = 1;
        tick();
        n_checks++;
        if (dut.state !== IDLE || {s_wen, s_ren, s_addr, s_wdata, s_strobe} !== '0) begin
            n_fail++; $display("FAIL rst_mid_idle: got state=%0d s_ren=%b s_addr=%h want %0d 0 0", dut.state, s_ren, s_addr, IDLE);
        end
        n_checks++;
        if (m1_stall !== 1'b1 || m1_error !== 1'b0 || m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_m1: got stall=%b err=%b rdata=%h want 1 0 0", m1_stall, m1_error, m1_rdata);
        end
        reset = 0; s_request_stall = 0;
        m0_ren = 1; m0_addr = 32'h10;
        tick();
        n_checks++;
        if (s_addr !== 32'h10 || m0_stall !== 1'b0 || m1_stall !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_tie: got s_addr=%h m0_stall=%b m1_stall=%b want 10 0 1", s_addr, m0_stall, m1_stall);
        end
        tick();
        m0_ren = 0; m1_ren = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stalled_read();
        test_malformed();
        test_abort();
        test_timeout();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
